regfile_2r1w: RTL and testbench
===============================

# regfile_2r1w

Parametrised register file, successor to the 8×16 single-port-pair register file in the lab datapath. It provides one write port and two independent registered read ports, so an ALU can fetch both operands in one cycle. Reads and writes proceed in the same cycle, with write-to-read bypass. A sequenced bulk-clear engine zeroes the array on request.

## Interface
Parameters:
- `WIDTH`, 16, data width in bits.
- `DEPTH`, 8, number of registers; must be ≥2, need not be a power of two.
- `AW`, `$clog2(DEPTH)`, localparam, address width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `write`  in  1  write enable.
- `writenum`  in  AW  write address.
- `data_in`  in  WIDTH  write data.
- `read_a`  in  1  port A read enable.
- `readnum_a`  in  AW  port A read address.
- `data_out_a`  out  WIDTH  port A registered read data.
- `read_b`  in  1  port B read enable.
- `readnum_b`  in  AW  port B read address.
- `data_out_b`  out  WIDTH  port B registered read data.
- `clear_req`  in  1  single-cycle request to zero all registers.
- `busy`  out  1  high while the clear sequence runs.

## Operation
- Reset (`rst_n`=0, any time, including mid-clear):
  - all registers → 0
  - `data_out_a` and `data_out_b` → 0
  - `busy` → 0
  - FSM → IDLE, clear index → 0
- Write: when `write`=1, `busy`=0 and `writenum`<DEPTH, `reg[writenum]` ← `data_in` at the edge.
- Writes with `writenum`≥DEPTH are dropped.
- Writes while `busy`=1 are dropped silently; no stall, no error flag.
- Read (each port independently): when `read_x`=1, `data_out_x` ← `reg[readnum_x]` at the edge.
- When `read_x`=0, `data_out_x` holds its value.
- `readnum_x`≥DEPTH returns 0.
- Bypass: if an accepted write targets `readnum_x` in the same cycle, `data_out_x` gets `data_in` (new value, not old).
- Both ports may read the same address, including a bypassed address; both get the same value.
- Reads are permitted during clear:
  - a register already cleared, or being cleared this cycle, reads 0;
  - a register not yet reached reads its old contents.
- Clear FSM:
  - States: IDLE, CLEAR.
  - IDLE → CLEAR when `clear_req`=1; index ← 0.
  - In CLEAR, each cycle: `reg[index]` ← 0, index ← index+1.
  - CLEAR → IDLE on the cycle that clears index DEPTH-1.
  - `clear_req` while in CLEAR is ignored; it does not restart or extend the sequence.
  - `busy` = (state == CLEAR), a registered output.
- A write accepted in the same cycle that `clear_req` is sampled in IDLE still takes effect, then gets cleared in sequence.

## Timing
- Read latency: 1 cycle. Address presented before edge N; data valid after edge N.
- Write latency: 1 cycle. Data written at edge N is readable by a read issued before edge N via bypass, and by normal reads issued after edge N.
- Clear duration: exactly DEPTH cycles of `busy`=1.
  - Request sampled at edge N.
  - `busy` rises after edge N.
  - `reg[k]` is zeroed at edge N+1+k.
  - `busy` falls after edge N+DEPTH.
  - First write accepted at edge N+DEPTH+1.
- Asynchronous reset takes effect immediately. Deassertion is synchronised externally; the block needs no recovery cycles.

## Structure
- Shared package `regfile_pkg`:
  - `clr_state_t` enum {IDLE, CLEAR};
  - default width and depth constants.
- One sub-module, `regfile_clear_ctrl`: the FSM plus index counter. Outputs `busy`, `clr_en` and `clr_idx`.
- The array, write decode, bypass muxes and read registers live in the top module.

## Test plan
- Reset then read all addresses on both ports: every read returns 0x0000, `busy`=0.
- Write 0x1234→r3 and 0xBEEF→r5; then read A=r3, B=r5 in one cycle: next cycle A=0x1234, B=0xBEEF.
- Same cycle: write 0xA5A5→r2 with A=r2 and B=r2: both outputs show 0xA5A5 after the edge; a read of r2 on the following cycle also returns 0xA5A5.
- Fill r0–r7 with 0x0001–0x0008, pulse `clear_req`, then:
  - `busy` stays high exactly 8 cycles;
  - reading r7 on the first CLEAR cycle returns 0x0008;
  - a write 0xFFFF→r7 on cycle 3 of CLEAR is dropped;
  - after `busy` falls, all registers read 0.
- With DEPTH=6: a write to address 7 is dropped, a read of address 6 returns 0, and the clear lasts 6 cycles.
- Assert `rst_n`=0 on cycle 2 of a clear: `busy`=0 and outputs are 0 immediately; after release, all registers read 0 and a new write/read works normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the two-read, one-write register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Bulk-clear sequencer: walks an index over every register,
// one per cycle, while holding busy high.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  clr_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_idx <= '0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          // requests arriving mid-sequence are ignored
          if (clr_idx == LAST) begin
            state   <= IDLE;
            clr_idx <= '0;
            busy    <= 1'b0;
          end else begin
            clr_idx <= clr_idx + ONE;
          end
        end
      endcase
    end
  end

  assign clr_en = (state == CLEAR);

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with one write port, two registered read ports,
// write-to-read bypass and a sequenced bulk clear.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic [AW-1:0]    writenum,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_a,
  input  logic [AW-1:0]    readnum_a,
  output logic [WIDTH-1:0] data_out_a,
  input  logic             read_b,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_b,
  input  logic             clear_req,
  output logic             busy
);

  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             clr_en;
  logic [AW-1:0]    clr_idx;
  logic             wr_ok;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  regfile_clear_ctrl #(
    .DEPTH (DEPTH)
  ) u_clr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_en    (clr_en),
    .clr_idx   (clr_idx)
  );

  assign wr_ok = write && !busy
              && ({1'b0, writenum} < DEPTH_V);

  // Priority: accepted write, then in-flight clear, then array.
  // Out-of-range addresses match no entry and fall to zero.
  function automatic logic [WIDTH-1:0] lookup(
    input logic [AW-1:0] addr
  );
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) v = mem[i];
    end
    if (clr_en && addr == clr_idx) v = '0;
    if (wr_ok && addr == writenum) v = data_in;
    return v;
  endfunction

  always_comb begin
    rd_a = lookup(readnum_a);
    rd_b = lookup(readnum_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && writenum == AW'(i)) begin
          mem[i] <= data_in;
        end else if (clr_en && clr_idx == AW'(i)) begin
          mem[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_a <= '0;
      data_out_b <= '0;
    end else begin
      if (read_a) data_out_a <= rd_a;
      if (read_b) data_out_b <= rd_b;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: depth-8 and depth-6 instances on shared
// stimulus, checked every cycle against an array model.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic        read_a;
  logic [2:0]  readnum_a;
  logic        read_b;
  logic [2:0]  readnum_b;
  logic        clear_req;

  logic [15:0] oa8, ob8, oa6, ob6;
  logic        bz8, bz6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(16), .DEPTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .write(write), .writenum(writenum), .data_in(data_in),
    .read_a(read_a), .readnum_a(readnum_a), .data_out_a(oa8),
    .read_b(read_b), .readnum_b(readnum_b), .data_out_b(ob8),
    .clear_req(clear_req), .busy(bz8)
  );

  regfile_2r1w #(.WIDTH(16), .DEPTH(6)) u6 (
    .clk(clk), .rst_n(rst_n),
    .write(write), .writenum(writenum), .data_in(data_in),
    .read_a(read_a), .readnum_a(readnum_a), .data_out_a(oa6),
    .read_b(read_b), .readnum_b(readnum_b), .data_out_b(ob6),
    .clear_req(clear_req), .busy(bz6)
  );

  // ---------------- reference model ----------------
  logic [15:0] m [2][8];
  int          left [2];
  int          nxt [2];
  logic [15:0] ea [2];
  logic [15:0] eb [2];
  logic        eby [2];

  function automatic int dep(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic logic [15:0] mread(
    input int k, input int addr, input bit acc, input bit bsy
  );
    if (addr >= dep(k)) return 16'h0;
    if (acc && int'(writenum) == addr) return data_in;
    if (bsy && addr == nxt[k]) return 16'h0;
    return m[k][addr];
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          for (int i = 0; i < 8; i++) m[k][i] = 16'h0;
          left[k] = 0;
          nxt[k]  = 0;
          ea[k]   = 16'h0;
          eb[k]   = 16'h0;
          eby[k]  = 1'b0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          bit bsy;
          bit acc;
          bsy = left[k] > 0;
          acc = write && !bsy && int'(writenum) < dep(k);
          if (read_a) ea[k] = mread(k, int'(readnum_a), acc, bsy);
          if (read_b) eb[k] = mread(k, int'(readnum_b), acc, bsy);
          if (acc) m[k][writenum] = data_in;
          if (bsy) begin
            m[k][nxt[k]] = 16'h0;
            nxt[k]  = nxt[k] + 1;
            left[k] = left[k] - 1;
          end else if (clear_req) begin
            left[k] = dep(k);
            nxt[k]  = 0;
          end
          eby[k] = left[k] > 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("model_a8", 32'(oa8), 32'(ea[0]));
        chk("model_b8", 32'(ob8), 32'(eb[0]));
        chk("model_busy8", 32'(bz8), 32'(eby[0]));
        chk("model_a6", 32'(oa6), 32'(ea[1]));
        chk("model_b6", 32'(ob6), 32'(eb[1]));
        chk("model_busy6", 32'(bz6), 32'(eby[1]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle;
    write = 0; writenum = 0; data_in = 0;
    read_a = 0; readnum_a = 0;
    read_b = 0; readnum_b = 0;
    clear_req = 0;
  endtask

  task automatic read_all_zero(input string nm);
    for (int i = 0; i < 8; i++) begin
      read_a = 1; readnum_a = 3'(i);
      read_b = 1; readnum_b = 3'(7 - i);
      step();
      chk({nm, "_a8"}, 32'(oa8), 32'h0);
      chk({nm, "_b8"}, 32'(ob8), 32'h0);
      chk({nm, "_a6"}, 32'(oa6), 32'h0);
      chk({nm, "_b6"}, 32'(ob6), 32'h0);
    end
    idle();
  endtask

  initial begin
    int n8;
    int n6;
    idle();
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_busy8", 32'(bz8), 32'h0);
    chk("rst_a8", 32'(oa8), 32'h0);
    chk("rst_b8", 32'(ob8), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    read_all_zero("reset_read");
    chk("reset_busy8", 32'(bz8), 32'h0);

    write = 1; writenum = 3; data_in = 16'h1234; step();
    write = 1; writenum = 5; data_in = 16'hBEEF; step();
    idle();
    read_a = 1; readnum_a = 3; read_b = 1; readnum_b = 5;
    step();
    chk("rd_r3", 32'(oa8), 32'h1234);
    chk("rd_r5", 32'(ob8), 32'hBEEF);

    idle();
    write = 1; writenum = 2; data_in = 16'hA5A5;
    read_a = 1; readnum_a = 2; read_b = 1; readnum_b = 2;
    step();
    chk("byp_a8", 32'(oa8), 32'hA5A5);
    chk("byp_b8", 32'(ob8), 32'hA5A5);
    chk("byp_a6", 32'(oa6), 32'hA5A5);
    idle();
    read_a = 1; readnum_a = 2;
    step();
    chk("after_byp", 32'(oa8), 32'hA5A5);

    idle();
    for (int i = 0; i < 8; i++) begin
      write = 1; writenum = 3'(i); data_in = 16'(i + 1);
      step();
    end
    idle();
    clear_req = 1;
    step();
    n8 = 0;
    n6 = 0;
    for (int c = 1; c <= 12; c++) begin
      if (bz8) n8++;
      if (bz6) n6++;
      idle();
      if (c == 1) begin read_a = 1; readnum_a = 7; end
      if (c == 2) clear_req = 1;
      if (c == 3) begin write = 1; writenum = 7; data_in = 16'hFFFF; end
      if (c == 5) begin read_a = 1; readnum_a = 7; end
      step();
      if (c == 1) chk("clr_first_r7", 32'(oa8), 32'h0008);
      if (c == 5) chk("clr_drop_r7", 32'(oa8), 32'h0008);
    end
    idle();
    chk("clr_len8", 32'(n8), 32'd8);
    chk("clr_len6", 32'(n6), 32'd6);
    read_all_zero("post_clear");

    write = 1; writenum = 7; data_in = 16'h7777; step();
    idle();
    read_a = 1; readnum_a = 7; read_b = 1; readnum_b = 6;
    step();
    chk("d8_r7", 32'(oa8), 32'h7777);
    chk("d8_r6", 32'(ob8), 32'h0);
    chk("d6_wr7_drop", 32'(oa6), 32'h0);
    chk("d6_rd6_zero", 32'(ob6), 32'h0);

    idle();
    write = 1; writenum = 1; data_in = 16'h1111; step();
    idle();
    clear_req = 1; step();
    idle();
    read_a = 1; readnum_a = 1; step();
    chk("pre_rst_r1", 32'(oa8), 32'h1111);
    #2 rst_n = 0;
    #1;
    chk("midclr_busy8", 32'(bz8), 32'h0);
    chk("midclr_busy6", 32'(bz6), 32'h0);
    chk("midclr_a8", 32'(oa8), 32'h0);
    chk("midclr_a6", 32'(oa6), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    idle();
    read_all_zero("post_rst");
    write = 1; writenum = 4; data_in = 16'h4444; step();
    idle();
    read_a = 1; readnum_a = 4; read_b = 1; readnum_b = 4;
    step();
    chk("post_rst_wr_a", 32'(oa8), 32'h4444);
    chk("post_rst_wr_b", 32'(ob8), 32'h4444);

    for (int n = 0; n < 3000; n++) begin
      write     = ($urandom_range(0, 1) == 1);
      writenum  = 3'($urandom_range(0, 7));
      data_in   = 16'($urandom);
      read_a    = ($urandom_range(0, 3) != 0);
      readnum_a = ($urandom_range(0, 2) == 0) ? writenum
                                              : 3'($urandom_range(0, 7));
      read_b    = ($urandom_range(0, 3) != 0);
      readnum_b = ($urandom_range(0, 3) == 0) ? readnum_a
                                              : 3'($urandom_range(0, 7));
      clear_req = ($urandom_range(0, 39) == 0);
      step();
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
